// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// a req/ack handshake, holds it for decode until the datapath finishes, then
// selects the next PC from jump/branch decode and the ALU zero flag.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        ex_done,
    input  logic        Branch_eq,
    input  logic        Branch_ne,
    input  logic        Jump,
    input  logic        zero,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_n, inst_n, count_n;
    logic        valid_n, req_n;

    logic [31:0] branch_off, branch_target, jump_target, next_pc;
    logic        take_branch;

    // Decode fields and the address bus are pure wiring off registered state.
    assign op        = inst[31:26];
    assign func      = inst[5:0];
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // Next-PC selection: jump beats branch; with both branch flags set one of
    // the two conditions is always true, so the branch is taken.
    always_comb begin
        branch_off    = {{14{inst[15]}}, inst[15:0], 2'b00};
        branch_target = pc_plus4 + branch_off;
        jump_target   = {pc_plus4[31:28], inst[25:0], 2'b00};
        take_branch   = (Branch_eq & zero) | (Branch_ne & ~zero);
        if (Jump)
            next_pc = jump_target;
        else if (take_branch)
            next_pc = branch_target;
        else
            next_pc = pc_plus4;
    end

    // State register plus all registered outputs; reset abandons any fetch.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its peers, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
            inst_count <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            inst_valid <= valid_n;
            imem_req   <= req_n;
            inst_count <= count_n;
        end
    end

    // Next-state and next-output logic; inputs outside their state are ignored.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_n = state;
        pc_n    = pc;
        inst_n  = inst;
        valid_n = inst_valid;
        req_n   = imem_req;
        count_n = inst_count;
        case (state)
            IDLE: begin
                state_n = REQ;
                req_n   = 1'b1;
            end
            REQ: begin
                if (imem_ack) begin
                    inst_n  = imem_rdata;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (ex_done) begin
                    pc_n    = next_pc;
                    valid_n = 1'b0;
                    req_n   = 1'b1;
                    count_n = inst_count + 32'd1;
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                req_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. Two instances share all inputs:
// one at RESET_PC=0, one at RESET_PC=32'h4000_0040 so that jump targets
// exercise a nonzero upper PC nibble.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ex_done, Branch_eq, Branch_ne, Jump, zero;

    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc, pc_plus4, inst_count;
    logic [5:0]  op, func;

    logic        req2, valid2;
    logic [31:0] addr2, inst2, pc2, pc4_2, count2;
    logic [5:0]  op2, func2;

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ex_done(ex_done), .Branch_eq(Branch_eq), .Branch_ne(Branch_ne),
        .Jump(Jump), .zero(zero),
        .inst(inst), .op(op), .func(func), .inst_valid(inst_valid),
        .pc(pc), .pc_plus4(pc_plus4), .inst_count(inst_count)
    );

    inst_fetch_unit #(.RESET_PC(32'h4000_0040)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ex_done(ex_done), .Branch_eq(Branch_eq), .Branch_ne(Branch_ne),
        .Jump(Jump), .zero(zero),
        .inst(inst2), .op(op2), .func(func2), .inst_valid(valid2),
        .pc(pc2), .pc_plus4(pc4_2), .inst_count(count2)
    );

    typedef struct {
        logic [31:0] rdata;
        int          wt;
        logic        beq, bne, jmp, zr;
        logic [31:0] pc_exp;
        logic [31:0] next_exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;
    bit jumped = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Second instance sits 0x4000_0040 above the first until a jump replaces
    // the offset with its upper nibble, after which it is 0x4000_0000.
    function automatic logic [31:0] hi(input logic [31:0] p);
        return p + (jumped ? 32'h4000_0000 : 32'h4000_0040);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after an edge with the DUT in REQ.
    task automatic fetch(input vec_t v, input logic [31:0] cnt);
        check("req_in_req", {31'd0, imem_req}, 32'd1);
        check("addr_in_req", imem_addr, v.pc_exp);
        check("valid_in_req", {31'd0, inst_valid}, 32'd0);
        for (int w = 0; w < v.wt; w++) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hBAD0_0000 | w;
            ex_done    = 1'b1;          // spurious: not in HOLD
            tick();
            check("addr_wait", imem_addr, v.pc_exp);
            check("req_wait", {31'd0, imem_req}, 32'd1);
            check("valid_wait", {31'd0, inst_valid}, 32'd0);
            check("count_wait", inst_count, cnt);
        end
        ex_done    = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        tick();
        imem_ack   = 1'b0;
        check("valid_fetch", {31'd0, inst_valid}, 32'd1);
        check("inst", inst, v.rdata);
        check("op", {26'd0, op}, {26'd0, v.rdata[31:26]});
        check("func", {26'd0, func}, {26'd0, v.rdata[5:0]});
        check("pc", pc, v.pc_exp);
        check("pc_plus4", pc_plus4, v.pc_exp + 32'd4);
        check("req_hold", {31'd0, imem_req}, 32'd0);
        check("pc_hi", pc2, hi(v.pc_exp));
        check("addr_hi", addr2, hi(v.pc_exp));
        check("pc4_hi", pc4_2, hi(v.pc_exp) + 32'd4);
        check("inst_hi", inst2, v.rdata);
        check("opfunc_hi", {20'd0, op2, func2}, {20'd0, v.rdata[31:26], v.rdata[5:0]});
    endtask

    // Entered just after the fetch edge with the DUT in HOLD.
    task automatic execute(input vec_t v, input logic [31:0] cnt);
        // Spurious ack and decode inputs without ex_done: nothing may move.
        imem_ack   = 1'b1;
        imem_rdata = ~v.rdata;
        Jump = 1'b1; Branch_eq = 1'b1; Branch_ne = 1'b0; zero = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("inst_frozen", inst, v.rdata);
        check("pc_frozen", pc, v.pc_exp);
        check("valid_held", {31'd0, inst_valid}, 32'd1);
        check("count_held", inst_count, cnt);
        Jump = v.jmp; Branch_eq = v.beq; Branch_ne = v.bne; zero = v.zr;
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        Jump = 1'b0; Branch_eq = 1'b0; Branch_ne = 1'b0; zero = 1'b0;
        if (v.jmp) jumped = 1'b1;
        check("next_pc", pc, v.next_exp);
        check("next_pc_hi", pc2, hi(v.next_exp));
        check("valid_drop", {31'd0, inst_valid}, 32'd0);
        check("req_rise", {31'd0, imem_req}, 32'd1);
        check("count", inst_count, cnt + 32'd1);
        check("count_hi", count2, cnt + 32'd1);
        check("valid_drop_hi", {30'd0, valid2, req2}, 32'd1);
    endtask

    initial begin
        //           rdata         wt beq bne jmp zr  pc            next
        vecs[0]  = '{32'h0000_0020, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{32'h012A_4020, 3, 0, 0, 0, 0, 32'h0000_0004, 32'h0000_0008};
        vecs[2]  = '{32'h8D09_0004, 3, 0, 0, 0, 0, 32'h0000_0008, 32'h0000_000C};
        vecs[3]  = '{32'h0800_0004, 1, 0, 0, 1, 0, 32'h0000_000C, 32'h0000_0010};
        vecs[4]  = '{32'h1000_FFFC, 0, 1, 0, 0, 1, 32'h0000_0010, 32'h0000_0004};
        vecs[5]  = '{32'h0800_0004, 0, 0, 0, 1, 0, 32'h0000_0004, 32'h0000_0010};
        vecs[6]  = '{32'h1000_FFFC, 2, 1, 0, 0, 0, 32'h0000_0010, 32'h0000_0014};
        vecs[7]  = '{32'h0800_0008, 0, 0, 0, 1, 0, 32'h0000_0014, 32'h0000_0020};
        vecs[8]  = '{32'h1400_0002, 0, 0, 1, 0, 0, 32'h0000_0020, 32'h0000_002C};
        vecs[9]  = '{32'h0800_0100, 0, 1, 0, 1, 1, 32'h0000_002C, 32'h0000_0400};
        vecs[10] = '{32'h1400_FFFF, 0, 0, 1, 0, 1, 32'h0000_0400, 32'h0000_0404};
        vecs[11] = '{32'h1000_0001, 0, 1, 1, 0, 0, 32'h0000_0404, 32'h0000_040C};
        vecs[12] = '{32'h1000_0001, 0, 1, 1, 0, 1, 32'h0000_040C, 32'h0000_0414};
        vecs[13] = '{32'h0BFF_FFFF, 0, 0, 0, 1, 0, 32'h0000_0414, 32'h0FFF_FFFC};
        vecs[14] = '{32'h0000_0000, 1, 0, 0, 0, 0, 32'h0FFF_FFFC, 32'h1000_0000};

        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; ex_done = 1'b0;
        Branch_eq = 1'b0; Branch_ne = 1'b0; Jump = 1'b0; zero = 1'b0;
        #12;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_count", inst_count, 32'h0);
        check("rst_pc_hi", pc2, 32'h4000_0040);

        tick();
        rst_n = 1'b1;
        tick();                          // edge 1: IDLE -> REQ
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_valid", {31'd0, inst_valid}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            fetch(vecs[i], i);
            execute(vecs[i], i);
        end

        // Asynchronous reset in REQ while an ack is still pending.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_count", inst_count, 32'h0);
        check("mid_rst_pc_hi", pc2, 32'h4000_0040);

        // Late ack straddling reset release must not be taken in IDLE.
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("late_ack_valid", {31'd0, inst_valid}, 32'd0);
        check("late_ack_inst", inst, 32'h0);
        check("late_ack_req", {31'd0, imem_req}, 32'd1);

        jumped = 1'b0;
        fetch(vecs[0], 0);
        execute(vecs[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
